// File: rtl/cv32e40px_x_coproc_frontend.sv
// ----------------------------------------------------------------------------
// cv32e40px_x_coproc_frontend
//
// Coprocessor-side responder for the CORE-V-XIF issue / commit / result
// channels driven by the cv32e40px dispatcher.
//  - Decodes offloaded custom-0 instructions and answers the issue handshake.
//  - Holds accepted instructions in an in-order queue until commit or kill.
//  - Executes committed instructions in a fixed-latency ALU pipe and returns
//    the rd writeback on the result channel (results leave in issue order).
//  - No memory channel: loadstore and dualread responses are tied low.
//
// Optional feature (compile-time macro):
//  CV32E40PX_XCOPROC_MINMAX_EN  - when defined, funct3 100 (MIN) and 101 (MAX),
//                                 both signed, are decoded as hits. When not
//                                 defined they are rejected (accept = 0).
//
// Parameters:
//  DEPTH       queue entries (power of 2, >= 2)
//  LATENCY     exec stages from queue pop to result valid (>= 1)
//  X_ID_WIDTH  instruction id width
//
// Ports:
//  clk_i, rst_ni                      clock, asynchronous active-low reset
//  x_issue_*                          issue request / response channel
//  x_commit_*                         commit (kill_i = 0) or kill (kill_i = 1)
//  x_result_*                         result channel, held stable until ready
//  busy_o                             queue or exec pipe holds an instruction
// ----------------------------------------------------------------------------
module cv32e40px_x_coproc_frontend #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned X_ID_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  x_issue_valid_i,
   output logic                  x_issue_ready_o,
   input  logic [31:0]           x_issue_req_instr_i,
   input  logic [X_ID_WIDTH-1:0] x_issue_req_id_i,
   input  logic [1:0][31:0]      x_issue_req_rs_i,
   input  logic [1:0]            x_issue_req_rs_valid_i,
   output logic                  x_issue_resp_accept_o,
   output logic                  x_issue_resp_writeback_o,
   output logic                  x_issue_resp_dualread_o,
   output logic                  x_issue_resp_loadstore_o,
   input  logic                  x_commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] x_commit_id_i,
   input  logic                  x_commit_kill_i,
   output logic                  x_result_valid_o,
   input  logic                  x_result_ready_i,
   output logic [X_ID_WIDTH-1:0] x_result_id_o,
   output logic [4:0]            x_result_rd_o,
   output logic [31:0]           x_result_data_o,
   output logic                  x_result_we_o,
   output logic                  busy_o
);

   localparam int unsigned      PTR_W       = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
   localparam logic [6:0]       OPC_CUSTOM0 = 7'b0001011;

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------
   function automatic logic op_supported(input logic [2:0] f3);
      logic sup;
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b011: sup = 1'b1;
`ifdef CV32E40PX_XCOPROC_MINMAX_EN
         3'b100, 3'b101:                 sup = 1'b1;
`endif
         default:                        sup = 1'b0;
      endcase
      return sup;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'b000:  r = a + b;
         3'b001:  r = a - b;
         3'b010:  r = a ^ b;
         3'b011:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef CV32E40PX_XCOPROC_MINMAX_EN
         3'b100:  r = ($signed(a) < $signed(b)) ? a : b;
         3'b101:  r = ($signed(a) < $signed(b)) ? b : a;
`endif
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [DEPTH-1:0]      q_valid_q, q_valid_d;
   logic [DEPTH-1:0]      q_cmt_q,   q_cmt_d;
   logic [DEPTH-1:0]      q_kill_q,  q_kill_d;
   logic [X_ID_WIDTH-1:0] q_id_q  [DEPTH];
   logic [X_ID_WIDTH-1:0] q_id_d  [DEPTH];
   logic [4:0]            q_rd_q  [DEPTH];
   logic [4:0]            q_rd_d  [DEPTH];
   logic [2:0]            q_op_q  [DEPTH];
   logic [2:0]            q_op_d  [DEPTH];
   logic [31:0]           q_rs1_q [DEPTH];
   logic [31:0]           q_rs1_d [DEPTH];
   logic [31:0]           q_rs2_q [DEPTH];
   logic [31:0]           q_rs2_d [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;

   logic [LATENCY-1:0]    st_valid_q, st_valid_d;
   logic [X_ID_WIDTH-1:0] st_id_q   [LATENCY];
   logic [X_ID_WIDTH-1:0] st_id_d   [LATENCY];
   logic [4:0]            st_rd_q   [LATENCY];
   logic [4:0]            st_rd_d   [LATENCY];
   logic [31:0]           st_data_q [LATENCY];
   logic [31:0]           st_data_d [LATENCY];

   // -------------------------------------------------------------------------
   // Decode and issue handshake
   // -------------------------------------------------------------------------
   logic [6:0] opcode_s;
   logic [6:0] funct7_s;
   logic [2:0] funct3_s;
   logic [4:0] rd_s;
   logic       hit_s;
   logic       unused_instr_bits;

   assign opcode_s = x_issue_req_instr_i[6:0];
   assign rd_s     = x_issue_req_instr_i[11:7];
   assign funct3_s = x_issue_req_instr_i[14:12];
   assign funct7_s = x_issue_req_instr_i[31:25];
   // Register specifiers rs1/rs2 arrive as values, so their fields are unused.
   assign unused_instr_bits = ^x_issue_req_instr_i[24:15];

   assign hit_s = (opcode_s == OPC_CUSTOM0) && (funct7_s == 7'd0) && op_supported(funct3_s);

   logic pipe_adv_s;
   logic head_vld_s;
   logic pop_exec_s;
   logic pop_drop_s;
   logic pop_s;
   logic full_s;
   logic issue_ready_s;
   logic issue_hs_s;
   logic enq_s;
   logic same_commit_s;

   // The whole pipe stalls while an unaccepted result sits on the output.
   assign pipe_adv_s = ~st_valid_q[LATENCY-1] | x_result_ready_i;
   assign head_vld_s = q_valid_q[head_q];
   assign pop_exec_s = head_vld_s & q_cmt_q[head_q] & ~q_kill_q[head_q] & pipe_adv_s;
   // Killed heads leave without touching the pipe, so they never wait on a stall.
   assign pop_drop_s = head_vld_s & q_kill_q[head_q];
   assign pop_s      = pop_exec_s | pop_drop_s;
   // Entries are contiguous, so a valid tail slot means the queue is full;
   // a same-cycle pop frees the slot the new entry will occupy.
   assign full_s     = q_valid_q[tail_q] & ~pop_s;

   assign issue_ready_s = ~hit_s | (~full_s & (x_issue_req_rs_valid_i == 2'b11));
   assign issue_hs_s    = x_issue_valid_i & issue_ready_s;
   assign enq_s         = issue_hs_s & hit_s;
   assign same_commit_s = x_commit_valid_i & (x_commit_id_i == x_issue_req_id_i);

   assign x_issue_ready_o          = issue_ready_s;
   assign x_issue_resp_accept_o    = enq_s;
   assign x_issue_resp_writeback_o = enq_s & (rd_s != 5'd0);
   assign x_issue_resp_dualread_o  = 1'b0;
   assign x_issue_resp_loadstore_o = 1'b0;

   // -------------------------------------------------------------------------
   // Next-state: commit marking, pop, enqueue and exec pipe shift
   // -------------------------------------------------------------------------
   always_comb begin
      q_valid_d  = q_valid_q;
      q_cmt_d    = q_cmt_q;
      q_kill_d   = q_kill_q;
      q_id_d     = q_id_q;
      q_rd_d     = q_rd_q;
      q_op_d     = q_op_q;
      q_rs1_d    = q_rs1_q;
      q_rs2_d    = q_rs2_q;
      head_d     = head_q;
      tail_d     = tail_q;
      st_valid_d = st_valid_q;
      st_id_d    = st_id_q;
      st_rd_d    = st_rd_q;
      st_data_d  = st_data_q;

      // Commit/kill marks the live entry carrying the id; unknown ids are ignored.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (x_commit_valid_i && q_valid_q[i] && (q_id_q[i] == x_commit_id_i)) begin
            q_cmt_d[i]  = q_cmt_q[i]  | ~x_commit_kill_i;
            q_kill_d[i] = q_kill_q[i] |  x_commit_kill_i;
         end else begin
            q_cmt_d[i]  = q_cmt_q[i];
            q_kill_d[i] = q_kill_q[i];
         end
      end

      if (pop_s) begin
         q_valid_d[head_q] = 1'b0;
         head_d            = head_q + PTR_ONE;
      end else begin
         head_d            = head_q;
      end

      // Enqueue last so it overrides a pop of the same slot when full.
      if (enq_s) begin
         q_valid_d[tail_q] = 1'b1;
         q_cmt_d[tail_q]   = same_commit_s & ~x_commit_kill_i;
         q_kill_d[tail_q]  = same_commit_s &  x_commit_kill_i;
         q_id_d[tail_q]    = x_issue_req_id_i;
         q_rd_d[tail_q]    = rd_s;
         q_op_d[tail_q]    = funct3_s;
         q_rs1_d[tail_q]   = x_issue_req_rs_i[0];
         q_rs2_d[tail_q]   = x_issue_req_rs_i[1];
         tail_d            = tail_q + PTR_ONE;
      end else begin
         tail_d            = tail_q;
      end

      // Result is computed at pop; later stages only carry it to the output.
      if (pipe_adv_s) begin
         st_valid_d[0] = pop_exec_s;
         st_id_d[0]    = pop_exec_s ? q_id_q[head_q] : {X_ID_WIDTH{1'b0}};
         st_rd_d[0]    = pop_exec_s ? q_rd_q[head_q] : 5'd0;
         st_data_d[0]  = pop_exec_s ? alu(q_op_q[head_q], q_rs1_q[head_q], q_rs2_q[head_q])
                                    : 32'd0;
         for (int unsigned s = 1; s < LATENCY; s++) begin
            st_valid_d[s] = st_valid_q[s-1];
            st_id_d[s]    = st_id_q[s-1];
            st_rd_d[s]    = st_rd_q[s-1];
            st_data_d[s]  = st_data_q[s-1];
         end
      end else begin
         st_valid_d = st_valid_q;
      end
   end

   // State registers; reset discards queue, pipe and any pending result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_valid_q  <= '0;
         q_cmt_q    <= '0;
         q_kill_q   <= '0;
         q_id_q     <= '{default: '0};
         q_rd_q     <= '{default: '0};
         q_op_q     <= '{default: '0};
         q_rs1_q    <= '{default: '0};
         q_rs2_q    <= '{default: '0};
         head_q     <= '0;
         tail_q     <= '0;
         st_valid_q <= '0;
         st_id_q    <= '{default: '0};
         st_rd_q    <= '{default: '0};
         st_data_q  <= '{default: '0};
      end else begin
         q_valid_q  <= q_valid_d;
         q_cmt_q    <= q_cmt_d;
         q_kill_q   <= q_kill_d;
         q_id_q     <= q_id_d;
         q_rd_q     <= q_rd_d;
         q_op_q     <= q_op_d;
         q_rs1_q    <= q_rs1_d;
         q_rs2_q    <= q_rs2_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         st_valid_q <= st_valid_d;
         st_id_q    <= st_id_d;
         st_rd_q    <= st_rd_d;
         st_data_q  <= st_data_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign x_result_valid_o = st_valid_q[LATENCY-1];
   assign x_result_id_o    = st_id_q[LATENCY-1];
   assign x_result_rd_o    = st_rd_q[LATENCY-1];
   assign x_result_data_o  = st_data_q[LATENCY-1];
   assign x_result_we_o    = st_valid_q[LATENCY-1] & (st_rd_q[LATENCY-1] != 5'd0);
   assign busy_o           = (|q_valid_q) | (|st_valid_q);

endmodule

// File: tb/tb_cv32e40px_x_coproc_frontend.sv
// ----------------------------------------------------------------------------
// Directed, table-driven bench for cv32e40px_x_coproc_frontend (default
// parameters DEPTH=4, LATENCY=2, X_ID_WIDTH=4). Single-instruction vectors are
// applied from a table; queue-full, kill/commit, backpressure, operand-valid
// and mid-operation reset behaviour are covered by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_cv32e40px_x_coproc_frontend;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             issue_valid;
   logic             x_issue_ready_o;
   logic [31:0]      issue_instr;
   logic [3:0]       issue_id;
   logic [1:0][31:0] issue_rs;
   logic [1:0]       issue_rs_valid;
   logic             x_issue_resp_accept_o;
   logic             x_issue_resp_writeback_o;
   logic             x_issue_resp_dualread_o;
   logic             x_issue_resp_loadstore_o;
   logic             commit_valid;
   logic [3:0]       commit_id;
   logic             commit_kill;
   logic             x_result_valid_o;
   logic             result_ready;
   logic [3:0]       x_result_id_o;
   logic [4:0]       x_result_rd_o;
   logic [31:0]      x_result_data_o;
   logic             x_result_we_o;
   logic             busy_o;

   cv32e40px_x_coproc_frontend dut (
      .clk_i                    (clk_i),
      .rst_ni                   (rst_ni),
      .x_issue_valid_i          (issue_valid),
      .x_issue_ready_o          (x_issue_ready_o),
      .x_issue_req_instr_i      (issue_instr),
      .x_issue_req_id_i         (issue_id),
      .x_issue_req_rs_i         (issue_rs),
      .x_issue_req_rs_valid_i   (issue_rs_valid),
      .x_issue_resp_accept_o    (x_issue_resp_accept_o),
      .x_issue_resp_writeback_o (x_issue_resp_writeback_o),
      .x_issue_resp_dualread_o  (x_issue_resp_dualread_o),
      .x_issue_resp_loadstore_o (x_issue_resp_loadstore_o),
      .x_commit_valid_i         (commit_valid),
      .x_commit_id_i            (commit_id),
      .x_commit_kill_i          (commit_kill),
      .x_result_valid_o         (x_result_valid_o),
      .x_result_ready_i         (result_ready),
      .x_result_id_o            (x_result_id_o),
      .x_result_rd_o            (x_result_rd_o),
      .x_result_data_o          (x_result_data_o),
      .x_result_we_o            (x_result_we_o),
      .busy_o                   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [6:0]  opc;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [3:0]  id;
      logic [31:0] a;
      logic [31:0] b;
      logic        acc;
      logic        wb;
      logic [31:0] data;
   } vec_t;

   localparam int NV = 12;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, rd, opc};
   endfunction

   task automatic issue_one(input logic [31:0] instr, input logic [3:0] id,
                            input logic [31:0] a, input logic [31:0] b, input logic cmt,
                            output logic rdy, output logic acc, output logic wb);
      issue_valid    = 1'b1;
      issue_instr    = instr;
      issue_id       = id;
      issue_rs[0]    = a;
      issue_rs[1]    = b;
      issue_rs_valid = 2'b11;
      commit_valid   = cmt;
      commit_id      = id;
      commit_kill    = 1'b0;
      #1;
      rdy = x_issue_ready_o;
      acc = x_issue_resp_accept_o;
      wb  = x_issue_resp_writeback_o;
      tick();
      issue_valid    = 1'b0;
      issue_rs_valid = 2'b00;
      commit_valid   = 1'b0;
   endtask

   task automatic commit_one(input logic [3:0] id, input logic kill);
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = kill;
      tick();
      commit_valid = 1'b0;
      commit_kill  = 1'b0;
   endtask

   // Count result handshakes over n cycles, remembering the last one.
   task automatic collect(input int n, output int cnt, output logic [3:0] id,
                          output logic [4:0] rd, output logic [31:0] data);
      cnt  = 0;
      id   = 4'd0;
      rd   = 5'd0;
      data = 32'd0;
      for (int c = 0; c < n; c++) begin
         tick();
         if (x_result_valid_o && result_ready) begin
            cnt++;
            id   = x_result_id_o;
            rd   = x_result_rd_o;
            data = x_result_data_o;
         end
      end
   endtask

   localparam logic [6:0] CUS = 7'b0001011;

   initial begin
      logic        rdy, acc, wb;
      int          cnt, w;
      logic [3:0]  rid;
      logic [4:0]  rrd;
      logic [31:0] rdata;

      vec[0]  = '{CUS, 7'd0, 3'b000, 5'd5,  4'd3, 32'd7,          32'd9,          1'b1, 1'b1, 32'd16};
      vec[1]  = '{CUS, 7'd0, 3'b001, 5'd1,  4'd1, 32'd0,          32'd1,          1'b1, 1'b1, 32'hFFFF_FFFF};
      vec[2]  = '{CUS, 7'd0, 3'b010, 5'd10, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1, 32'hFF00_FF00};
      vec[3]  = '{CUS, 7'd0, 3'b011, 5'd31, 4'd4, 32'hFFFF_FFFF, 32'd1,          1'b1, 1'b1, 32'd1};
      vec[4]  = '{CUS, 7'd0, 3'b011, 5'd12, 4'd5, 32'd5,          32'hFFFF_FFFD, 1'b1, 1'b1, 32'd0};
      vec[5]  = '{CUS, 7'd0, 3'b000, 5'd0,  4'd6, 32'hFFFF_FFFF, 32'd2,          1'b1, 1'b0, 32'd1};
`ifdef CV32E40PX_XCOPROC_MINMAX_EN
      vec[6]  = '{CUS, 7'd0, 3'b100, 5'd7,  4'd7, 32'hFFFF_FFFB, 32'd3,          1'b1, 1'b1, 32'hFFFF_FFFB};
      vec[7]  = '{CUS, 7'd0, 3'b101, 5'd8,  4'd8, 32'hFFFF_FFFB, 32'd3,          1'b1, 1'b1, 32'd3};
`else
      vec[6]  = '{CUS, 7'd0, 3'b100, 5'd7,  4'd7, 32'hFFFF_FFFB, 32'd3,          1'b0, 1'b0, 32'd0};
      vec[7]  = '{CUS, 7'd0, 3'b101, 5'd8,  4'd8, 32'hFFFF_FFFB, 32'd3,          1'b0, 1'b0, 32'd0};
`endif
      vec[8]  = '{7'b0110011, 7'd0, 3'b000, 5'd5, 4'd9, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0};
      vec[9]  = '{CUS, 7'd1, 3'b000, 5'd5,  4'd10, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0};
      vec[10] = '{CUS, 7'd0, 3'b111, 5'd5,  4'd11, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0};
      vec[11] = '{CUS, 7'd0, 3'b110, 5'd5,  4'd12, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0};

      rst_ni         = 1'b0;
      issue_valid    = 1'b0;
      issue_instr    = 32'd0;
      issue_id       = 4'd0;
      issue_rs[0]    = 32'd0;
      issue_rs[1]    = 32'd0;
      issue_rs_valid = 2'b00;
      commit_valid   = 1'b0;
      commit_id      = 4'd0;
      commit_kill    = 1'b0;
      result_ready   = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_result_valid", x_result_valid_o, 1'b0);
      chk("rst_result_id",    x_result_id_o, 4'd0);
      chk("rst_result_rd",    x_result_rd_o, 5'd0);
      chk("rst_result_data",  x_result_data_o, 32'd0);
      chk("rst_result_we",    x_result_we_o, 1'b0);
      chk("rst_busy",         busy_o, 1'b0);
      chk("rst_accept",       x_issue_resp_accept_o, 1'b0);
      chk("rst_writeback",    x_issue_resp_writeback_o, 1'b0);
      chk("rst_dualread",     x_issue_resp_dualread_o, 1'b0);
      chk("rst_loadstore",    x_issue_resp_loadstore_o, 1'b0);
      rst_ni = 1'b1;
      tick();

      // Table: issue with same-cycle commit; result two cycles after the pop,
      // which happens the cycle after enqueue.
      for (int i = 0; i < NV; i++) begin
         issue_one(mk(vec[i].f7, vec[i].f3, vec[i].rd, vec[i].opc), vec[i].id,
                   vec[i].a, vec[i].b, 1'b1, rdy, acc, wb);
         chk($sformatf("v%0d_ready", i), rdy, 1'b1);
         chk($sformatf("v%0d_accept", i), acc, vec[i].acc);
         chk($sformatf("v%0d_writeback", i), wb, vec[i].wb);
         tick();
         chk($sformatf("v%0d_early_valid", i), x_result_valid_o, 1'b0);
         chk($sformatf("v%0d_busy", i), busy_o, vec[i].acc);
         tick();
         chk($sformatf("v%0d_result_valid", i), x_result_valid_o, vec[i].acc);
         if (vec[i].acc) begin
            chk($sformatf("v%0d_result_id", i), x_result_id_o, vec[i].id);
            chk($sformatf("v%0d_result_rd", i), x_result_rd_o, vec[i].rd);
            chk($sformatf("v%0d_result_data", i), x_result_data_o, vec[i].data);
            chk($sformatf("v%0d_result_we", i), x_result_we_o, (vec[i].rd != 5'd0));
         end
         tick();
         chk($sformatf("v%0d_result_done", i), x_result_valid_o, 1'b0);
         chk($sformatf("v%0d_idle", i), busy_o, 1'b0);
      end

      // Operands not yet valid: hit must wait, then complete exactly once.
      issue_valid    = 1'b1;
      issue_instr    = mk(7'd0, 3'b000, 5'd6, CUS);
      issue_id       = 4'd5;
      issue_rs[0]    = 32'd1;
      issue_rs[1]    = 32'd2;
      issue_rs_valid = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rsv_ready_low", x_issue_ready_o, 1'b0);
         chk("rsv_accept_low", x_issue_resp_accept_o, 1'b0);
         tick();
      end
      issue_rs_valid = 2'b11;
      #1;
      chk("rsv_ready_high", x_issue_ready_o, 1'b1);
      chk("rsv_accept_high", x_issue_resp_accept_o, 1'b1);
      tick();
      issue_valid    = 1'b0;
      issue_rs_valid = 2'b00;
      commit_one(4'd5, 1'b0);
      collect(8, cnt, rid, rrd, rdata);
      chk("rsv_result_count", cnt, 1);
      chk("rsv_result_id", rid, 4'd5);
      chk("rsv_result_data", rdata, 32'd3);

      // Queue full: four uncommitted hits block the fifth until a commit.
      for (int k = 0; k < 4; k++) begin
         issue_one(mk(7'd0, 3'b000, 5'(k + 1), CUS), 4'(k + 4), 32'(k), 32'd100, 1'b0,
                   rdy, acc, wb);
         chk($sformatf("fill%0d_accept", k), acc, 1'b1);
      end
      issue_valid    = 1'b1;
      issue_instr    = mk(7'd0, 3'b000, 5'd9, CUS);
      issue_id       = 4'd8;
      issue_rs[0]    = 32'd1;
      issue_rs[1]    = 32'd1;
      issue_rs_valid = 2'b11;
      #1;
      chk("full_ready_low", x_issue_ready_o, 1'b0);
      chk("full_busy", busy_o, 1'b1);
      tick();
      chk("full_ready_still_low", x_issue_ready_o, 1'b0);
      commit_one(4'd4, 1'b0);
      w = 0;
      while (!x_issue_ready_o && w < 8) begin
         tick();
         w++;
      end
      chk("full_ready_release", x_issue_ready_o, 1'b1);
      chk("full_fifth_accept", x_issue_resp_accept_o, 1'b1);
      tick();
      issue_valid    = 1'b0;
      issue_rs_valid = 2'b00;
      collect(6, cnt, rid, rrd, rdata);
      chk("full_result_count", cnt, 1);
      chk("full_result_id", rid, 4'd4);
      chk("full_result_data", rdata, 32'd100);
      for (int k = 5; k <= 8; k++) commit_one(4'(k), 1'b1);
      collect(6, cnt, rid, rrd, rdata);
      chk("full_killed_count", cnt, 0);
      chk("full_killed_idle", busy_o, 1'b0);

      // Kill id 1, commit id 2: only id 2 returns; SUB 0-1 wraps.
      issue_one(mk(7'd0, 3'b000, 5'd3, CUS), 4'd1, 32'd5, 32'd5, 1'b0, rdy, acc, wb);
      issue_one(mk(7'd0, 3'b001, 5'd4, CUS), 4'd2, 32'd0, 32'd1, 1'b0, rdy, acc, wb);
      commit_one(4'd1, 1'b1);
      commit_one(4'd2, 1'b0);
      collect(8, cnt, rid, rrd, rdata);
      chk("kill_result_count", cnt, 1);
      chk("kill_result_id", rid, 4'd2);
      chk("kill_result_rd", rrd, 5'd4);
      chk("kill_result_data", rdata, 32'hFFFF_FFFF);
      chk("kill_idle", busy_o, 1'b0);

      // Backpressure: result held for 5 cycles, next follows one cycle after ready.
      result_ready = 1'b0;
      issue_one(mk(7'd0, 3'b000, 5'd7, CUS), 4'd9,  32'd10,  32'd20, 1'b1, rdy, acc, wb);
      issue_one(mk(7'd0, 3'b010, 5'd8, CUS), 4'd10, 32'hF,   32'h3,  1'b1, rdy, acc, wb);
      w = 0;
      while (!x_result_valid_o && w < 10) begin
         tick();
         w++;
      end
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_valid", x_result_valid_o, 1'b1);
         chk("bp_hold_id", x_result_id_o, 4'd9);
         chk("bp_hold_data", x_result_data_o, 32'd30);
         tick();
      end
      result_ready = 1'b1;
      tick();
      chk("bp_next_valid", x_result_valid_o, 1'b1);
      chk("bp_next_id", x_result_id_o, 4'd10);
      chk("bp_next_data", x_result_data_o, 32'hC);
      tick();
      chk("bp_done_valid", x_result_valid_o, 1'b0);
      chk("bp_done_idle", busy_o, 1'b0);

      // Reset while an instruction is in the pipe: nothing comes out.
      issue_one(mk(7'd0, 3'b000, 5'd2, CUS), 4'd11, 32'd1, 32'd1, 1'b1, rdy, acc, wb);
      tick();
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_valid", x_result_valid_o, 1'b0);
      chk("rst_mid_busy", busy_o, 1'b0);
      tick();
      rst_ni = 1'b1;
      collect(6, cnt, rid, rrd, rdata);
      chk("rst_mid_no_result", cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
